// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among N_REQ renderers.
// One single-word read is granted per cycle, and the data returns tagged with the requester id.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int AW      = 8,
  parameter int DW      = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*AW-1:0]        addr,
  output logic [N_REQ-1:0]           gnt,
  output logic [AW-1:0]              rom_address,
  input  logic [DW-1:0]              rom_q,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [DW-1:0]              rsp_data
);

  localparam int IDW = $clog2(N_REQ);

  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("sprite_rom_arbiter: N_REQ must be in 2..8");
  end
  if ((ROM_LAT < 1) || (ROM_LAT > 3)) begin : g_bad_rom_lat
    $error("sprite_rom_arbiter: ROM_LAT must be in 1..3");
  end

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] win;
  logic           found;
  logic           grant;
  int             scan_idx;

  logic [ROM_LAT:0] vld_q;
  logic [IDW-1:0]   id_q [ROM_LAT+1];

  // Scan upward from ptr_q, wrapping. The first requester found wins.
  // NOTE: every variable gets a default before the loop. Otherwise some paths leave it unassigned and a latch is inferred.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = IDW'(scan_idx);
      end
    end
  end

  // Reset also blocks grants: the pointer is already 0 then, but no read may start.
  assign grant = found && en && reset_n;

  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then update together and simulation matches the hardware.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      rom_address <= '0;
    end else if (grant) begin
      ptr_q       <= (win == IDW'(N_REQ - 1)) ? '0 : win + IDW'(1);
      rom_address <= addr[int'(win)*AW +: AW];
    end
  end

  // Valid/id pipeline. Stage k describes the ROM word that is due k cycles after rom_address.
  // NOTE: this small pipeline is reset explicitly. A reset then drops in-flight reads, and rsp_id reads 0 at once.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k <= ROM_LAT; k++) id_q[k] <= '0;
    end else begin
      vld_q[0] <= grant;
      id_q[0]  <= grant ? win : '0;
      for (int k = 1; k <= ROM_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

  assign rsp_valid = vld_q[ROM_LAT];
  assign rsp_id    = id_q[ROM_LAT];
  assign rsp_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios followed by random traffic.
// Two instances (ROM_LAT 1 and 3) are checked against a queue-based reference model.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 4;

  logic            vga_clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;

  logic [N-1:0]  gnt1, gnt3;
  logic [AW-1:0] ra1, ra3;
  logic [DW-1:0] q1, q3, d1, d3;
  logic          v1, v3;
  logic [1:0]    id1, id3;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(1)) dut_l1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .addr(addr),
    .gnt(gnt1), .rom_address(ra1), .rom_q(q1),
    .rsp_valid(v1), .rsp_id(id1), .rsp_data(d1)
  );

  sprite_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(3)) dut_l3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .addr(addr),
    .gnt(gnt3), .rom_address(ra3), .rom_q(q3),
    .rsp_valid(v3), .rsp_id(id3), .rsp_data(d3)
  );

  // Behavioural synchronous ROMs with latency 1 and latency 3.
  logic [DW-1:0] rom [256];
  logic [AW-1:0] p1;
  logic [AW-1:0] p3 [3];
  always @(posedge vga_clk) begin
    p1    <= ra1;
    p3[0] <= ra3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q1 = rom[p1];
  assign q3 = rom[p3[2]];

  // Reference model: pointer, expected ROM address, and pending responses keyed by due cycle.
  typedef struct {
    int            due;
    int            id;
    logic [AW-1:0] a;
  } rsp_t;

  rsp_t          pend_l1[$];
  rsp_t          pend_l3[$];
  int            m_ptr;
  logic [AW-1:0] m_addr;
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock cycle: check everything at the falling edge, advance the model, then cross the rising edge.
  task automatic step();
    int         w;
    logic [N-1:0] eg;
    logic       ev;
    @(negedge vga_clk);
    if (!reset_n) begin
      m_ptr  = 0;
      m_addr = '0;
      pend_l1.delete();
      pend_l3.delete();
    end
    w  = (reset_n && en) ? rr_pick(req, m_ptr) : -1;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check("gnt_l1", 32'(gnt1), 32'(eg));
    check("gnt_l3", 32'(gnt3), 32'(eg));
    check("rom_address_l1", 32'(ra1), 32'(m_addr));
    check("rom_address_l3", 32'(ra3), 32'(m_addr));

    ev = (pend_l1.size() > 0) && (pend_l1[0].due == cyc);
    check("rsp_valid_l1", 32'(v1), 32'(ev));
    if (ev) begin
      check("rsp_id_l1", 32'(id1), pend_l1[0].id);
      check("rsp_data_l1", 32'(d1), 32'(rom[pend_l1[0].a]));
      void'(pend_l1.pop_front());
    end else begin
      check("rsp_id_idle_l1", 32'(id1), 0);
    end

    ev = (pend_l3.size() > 0) && (pend_l3[0].due == cyc);
    check("rsp_valid_l3", 32'(v3), 32'(ev));
    if (ev) begin
      check("rsp_id_l3", 32'(id3), pend_l3[0].id);
      check("rsp_data_l3", 32'(d3), 32'(rom[pend_l3[0].a]));
      void'(pend_l3.pop_front());
    end else begin
      check("rsp_id_idle_l3", 32'(id3), 0);
    end

    if (w >= 0) begin
      m_ptr  = (w + 1) % N;
      m_addr = addr[w*AW +: AW];
      pend_l1.push_back('{cyc + 2, w, m_addr});
      pend_l3.push_back('{cyc + 4, w, m_addr});
    end
    cyc++;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_ptr    = 0;
    m_addr   = '0;
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
    rom[8'h37] = 4'hA;

    reset_n = 1'b0;
    en      = 1'b1;
    req     = 4'b1111;
    addr    = {$urandom};
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("first_gnt_after_reset", 32'(gnt1), 32'(4'b0001));
    step();
    idle(5);

    // Single request from requester 2 at address 0x37.
    addr[2*AW +: AW] = 8'h37;
    req = 4'b0100;
    step();
    idle(5);

    // Full contention for eight cycles.
    addr = {$urandom};
    req  = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    idle(5);

    // Wrap: grant to 3, then 1001 twice gives 0 and then 3.
    req = 4'b1000; step();
    req = 4'b1001; step();
    req = 4'b1001; step();
    idle(5);

    // Enable gating: en drops after the first grant, then resumes.
    req = 4'b0011; step();
    en  = 1'b0; req = 4'b0010;
    for (int i = 0; i < 4; i++) step();
    en = 1'b1; step();
    idle(5);

    // Reset mid-flight, one cycle after a grant.
    req = 4'b0100; step();
    req = '0; reset_n = 1'b0; step();
    reset_n = 1'b1;
    idle(6);
    req = 4'b1111; step();
    idle(6);

    for (int i = 0; i < 3000; i++) begin
      req     = N'($urandom);
      en      = ($urandom_range(7) != 0);
      addr    = {$urandom};
      reset_n = ($urandom_range(99) != 0);
      step();
    end
    reset_n = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin read arbiter that shares one synchronous sprite ROM (e.g. `small_mario_rom`) among `N_REQ` pixel requesters: Mario, enemies, blocks, HUD. It sits between the per-object sprite renderers and the ROM. Each cycle it grants at most one single-word read and returns the ROM word tagged with the requester index after a fixed latency. Palette lookup stays downstream, driven from `rsp_data`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `AW`, default 8: ROM address width.
- `DW`, default 4: ROM data width (palette index).
- `ROM_LAT`, default 1: ROM read latency in cycles, from `rom_address` valid to `rom_q` valid (1..3).

Ports:
- `vga_clk`, in, 1: single clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: arbitration enable; 0 blocks new grants. In-flight reads still complete.
- `req`, in, `N_REQ`: per-requester read request, level; held until granted.
- `addr`, in, `N_REQ*AW`: packed addresses; requester i uses bits [i*AW +: AW].
- `gnt`, out, `N_REQ`: one-hot grant, combinational from `req`/`en`/pointer.
- `rom_address`, out, `AW`: registered address to ROM.
- `rom_q`, in, `DW`: ROM read data.
- `rsp_valid`, out, 1: `rsp_data` is valid this cycle.
- `rsp_id`, out, `$clog2(N_REQ)`: requester that owns `rsp_data`.
- `rsp_data`, out, `DW`: equals `rom_q` (passthrough).

## Operation
- State:
  - round-robin pointer `ptr` (`$clog2(N_REQ)` bits);
  - `rom_address` register;
  - valid/id shift pipeline of depth `ROM_LAT+1`.
- Arbitration, every cycle:
  - Scan `req` starting at index `ptr`, upward, wrapping at `N_REQ-1` → 0.
  - The first set bit is the winner.
  - `gnt` is one-hot on the winner only if `en`=1 and `req`≠0; otherwise `gnt`=0.
- On a grant to index w, at the rising edge:
  - `rom_address` <= `addr[w]`;
  - `ptr` <= (w+1) mod `N_REQ`;
  - pipeline stage 0 <= {valid=1, id=w}.
- No grant:
  - `rom_address` holds its value;
  - `ptr` holds;
  - stage 0 <= {valid=0, id=0}.
- The requester drops or changes `req`/`addr` in the cycle after seeing `gnt`. A `req` still high after its grant is treated as a new request.
- The pipeline advances every cycle unconditionally; there is no backpressure.
  - `rsp_valid`/`rsp_id` come from the last stage.
  - `rsp_data` = `rom_q`.
- Sustained throughput: one read per cycle. With all requesters active, each gets exactly 1 grant per `N_REQ` cycles.
- `en` falling: no new grants from that cycle on. Already-granted reads still produce their `rsp_valid` on schedule.
- `en` rising: arbitration resumes from the current `ptr`.

## Timing
- Grant in cycle t (gnt high during t):
  - `rom_address` valid in cycle t+1;
  - `rom_q` valid in cycle t+1+`ROM_LAT`;
  - `rsp_valid`=1 and `rsp_id`=w in cycle t+1+`ROM_LAT`.
- Default latency: grant at t → response at t+2.
- Back-to-back grants at t and t+1 give responses at consecutive cycles, in grant order.
- `gnt` has zero latency. `req` asserted in cycle t can be granted in cycle t.
- Reset (`reset_n`=0, asynchronous):
  - `ptr`=0, `rom_address`=0, all pipeline valid bits=0, ids=0;
  - so `rsp_valid`=0 and `rsp_id`=0 immediately;
  - `gnt`=0 while in reset.
- Reset mid-operation: in-flight reads are discarded and no `rsp_valid` appears for them after release.
- `rsp_data` is the raw `rom_q`. It is only meaningful when `rsp_valid`=1.
- Out-of-range widths: `N_REQ` outside 2..8 or `ROM_LAT` outside 1..3 is a parameter error, flagged by elaboration-time assertion.

## Test plan
- Reset check: hold `reset_n`=0 with `req`=4'b1111 → `gnt`=0, `rsp_valid`=0, `rom_address`=0. Release; the first grant is `gnt`=4'b0001.
- Single request: `req`=4'b0100 for 1 cycle at t, addr[2]=8'h37, ROM preloaded word 0x37=4'hA → `gnt`=4'b0100 at t, `rom_address`=8'h37 at t+1, `rsp_valid`=1 with `rsp_id`=2 and `rsp_data`=4'hA at t+2.
- Full contention: `req`=4'b1111 held 8 cycles → grants 0,1,2,3,0,1,2,3; responses are 8 consecutive `rsp_valid` cycles with ids in the same order, starting 2 cycles after the first grant.
- Fairness / wrap: after a grant to 3, `req`=4'b1001 → next grant goes to 0; then with `req`=4'b1001 again → grant goes to 3.
- Enable gating: `req`=4'b0011 with `en` dropped the cycle after the first grant → exactly one `rsp_valid` (id 0). On `en` re-assert, the next grant is to 1.
- Reset mid-flight: `reset_n` pulsed low 1 cycle after a grant → no `rsp_valid` for that read; `ptr` restarts at 0. Repeat with `ROM_LAT`=3 → response at t+4.
